gpio_port: RTL and testbench

- Memory-mapped GPIO peripheral downstream of the data-address decoder.
- Consumes decoder one-hot write strobe bit 1 (region 1, addresses 128..130) plus CPU address/write data.
- Holds output and direction registers, synchronises pad inputs, returns read data to the CPU load mux.

---
 rtl/gpio_pkg.sv | 27 ++
 rtl/gpio_sync.sv | 40 ++++
 rtl/gpio_port.sv | 131 +++++++++++++
 tb/tb_gpio_port.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// gpio_pkg
// Purpose: register map constants and address-window helper shared by the
//          GPIO port and the CPU data path.
// Ports:   none (package).
package gpio_pkg;

  // CPU data word width, also used by data_control
  localparam int REG_WIDTH = 32;

  // Register offsets relative to BASE_ADDR
  localparam logic [1:0] GPIO_OFF_OUT = 2'd0;
  localparam logic [1:0] GPIO_OFF_DIR = 2'd1;
  localparam logic [1:0] GPIO_OFF_IN  = 2'd2;
  localparam int         GPIO_NUM_REGS = 3;

  // IRQ status field position within DATA_IN
  localparam int GPIO_IRQ_SHIFT = 16;

  // True when addr falls inside [base, base + GPIO_NUM_REGS).
  // The subtraction is only trusted after the lower-bound test, so an
  // address below base never wraps into the window.
  function automatic logic addr_in_window(input logic [REG_WIDTH-1:0] addr,
                                          input logic [REG_WIDTH-1:0] base);
    return (addr >= base) && ((addr - base) < REG_WIDTH'(GPIO_NUM_REGS));
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// gpio_sync
// Purpose: multi-stage flop synchroniser for asynchronous pad inputs,
//          cleared by synchronous reset.
// Ports:
//   i_clk  - system clock
//   i_rst  - synchronous active-high reset, clears every stage
//   i_d    - asynchronous input bus (WIDTH bits)
//   o_q    - synchronised output, STAGES edges behind i_d
module gpio_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d;

    if (gi == 0) begin : g_first
      assign d = i_d;
    end else begin : g_chain
      assign d = g_stage[gi-1].q_reg;
    end

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        q_reg <= '0;
      end else begin
        q_reg <= d;
      end
    end
  end

  assign o_q = g_stage[STAGES-1].q_reg;

endmodule

// File: rtl/gpio_port.sv
// gpio_port
// Purpose: memory-mapped GPIO peripheral. Holds output and direction
//          registers, synchronises pad inputs and returns read data to the
//          CPU load mux. Register map (offset from BASE_ADDR):
//            0 DATA_OUT (RW), 1 DIR (RW, 1 = drive), 2 DATA_IN (RO pins,
//            IRQ status in the upper half when enabled, write-1-to-clear).
// Optional feature: define GPIO_IRQ_EN to add rising-edge interrupt logic;
//          without it o_irq is tied low and DATA_IN upper bits read 0.
// Ports:
//   i_clk      - system clock
//   i_rst      - synchronous active-high reset
//   i_we       - write strobe from the address decoder
//   i_addr     - CPU data address
//   i_wdata    - CPU store data (only the low GPIO_WIDTH bits are stored)
//   o_rdata    - combinational read data, 0 outside the register window
//   i_gpio_in  - asynchronous pad inputs
//   o_gpio_out - pad output values
//   o_gpio_oe  - pad output enables
//   o_irq      - registered interrupt request
module gpio_port
  import gpio_pkg::*;
#(
  parameter int GPIO_WIDTH  = 8,
  parameter int BASE_ADDR   = 128,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_we,
  input  logic [REG_WIDTH-1:0]  i_addr,
  input  logic [REG_WIDTH-1:0]  i_wdata,
  output logic [REG_WIDTH-1:0]  o_rdata,
  input  logic [GPIO_WIDTH-1:0] i_gpio_in,
  output logic [GPIO_WIDTH-1:0] o_gpio_out,
  output logic [GPIO_WIDTH-1:0] o_gpio_oe,
  output logic                  o_irq
);

  localparam logic [REG_WIDTH-1:0] BASE = REG_WIDTH'(BASE_ADDR);

  logic [REG_WIDTH-1:0]  offset;
  logic                  off_valid;
  logic                  wr_out;
  logic                  wr_dir;
  logic                  wr_in;
  logic [GPIO_WIDTH-1:0] out_reg;
  logic [GPIO_WIDTH-1:0] dir_reg;
  logic [GPIO_WIDTH-1:0] sync;
  logic [GPIO_WIDTH-1:0] status_view;

  assign offset    = i_addr - BASE;
  assign off_valid = addr_in_window(i_addr, BASE);
  assign wr_out    = i_we && off_valid && (offset[1:0] == GPIO_OFF_OUT);
  assign wr_dir    = i_we && off_valid && (offset[1:0] == GPIO_OFF_DIR);
  assign wr_in     = i_we && off_valid && (offset[1:0] == GPIO_OFF_IN);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      out_reg <= '0;
      dir_reg <= '0;
    end else begin
      if (wr_out) out_reg <= i_wdata[GPIO_WIDTH-1:0];
      if (wr_dir) dir_reg <= i_wdata[GPIO_WIDTH-1:0];
    end
  end

  gpio_sync #(
    .WIDTH  (GPIO_WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_gpio_in),
    .o_q   (sync)
  );

`ifdef GPIO_IRQ_EN
  logic [GPIO_WIDTH-1:0] hist_reg;
  logic [GPIO_WIDTH-1:0] irq_status_reg;
  logic [GPIO_WIDTH-1:0] irq_status_next;
  logic [GPIO_WIDTH-1:0] rise;
  logic [GPIO_WIDTH-1:0] clr;
  logic                  irq_reg;

  assign rise = sync & ~hist_reg;
  assign clr  = wr_in ? i_wdata[GPIO_IRQ_SHIFT +: GPIO_WIDTH] : '0;
  // Clear is applied first so a coincident edge re-sets the bit.
  assign irq_status_next = (irq_status_reg & ~clr) | rise;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hist_reg       <= '0;
      irq_status_reg <= '0;
      irq_reg        <= 1'b0;
    end else begin
      hist_reg       <= sync;
      irq_status_reg <= irq_status_next;
      irq_reg        <= |irq_status_reg;
    end
  end

  assign o_irq       = irq_reg;
  assign status_view = irq_status_reg;
`else
  assign o_irq       = 1'b0;
  assign status_view = '0;
`endif

  always_comb begin
    o_rdata = '0;
    if (off_valid) begin
      case (offset[1:0])
        GPIO_OFF_OUT: o_rdata[GPIO_WIDTH-1:0] = out_reg;
        GPIO_OFF_DIR: o_rdata[GPIO_WIDTH-1:0] = dir_reg;
        GPIO_OFF_IN: begin
          o_rdata[GPIO_WIDTH-1:0]              = sync;
          o_rdata[GPIO_IRQ_SHIFT +: GPIO_WIDTH] = status_view;
        end
        default: o_rdata = '0;
      endcase
    end
  end

  assign o_gpio_out = out_reg;
  assign o_gpio_oe  = dir_reg;

  // Upper store-data bits and upper offset bits are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{i_wdata, offset};

endmodule

// File: tb/tb_gpio_port.sv
// tb_gpio_port
// Purpose: randomized + directed bench for gpio_port. Stimulus pushes the
//          expected outputs of each cycle into a queue; a negedge monitor
//          pops and compares them against the DUT.
// Ports:   none (top-level bench). Honours GPIO_IRQ_EN like the RTL.
module tb_gpio_port;

  localparam int W    = 8;
  localparam int BASE = 128;
  localparam int S    = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          we;
  logic [31:0]   addr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic [W-1:0]  gin;
  logic [W-1:0]  gout;
  logic [W-1:0]  goe;
  logic          irq;

  always #5 clk = ~clk;

  gpio_port #(
    .GPIO_WIDTH  (W),
    .BASE_ADDR   (BASE),
    .SYNC_STAGES (S)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_we       (we),
    .i_addr     (addr),
    .i_wdata    (wdata),
    .o_rdata    (rdata),
    .i_gpio_in  (gin),
    .o_gpio_out (gout),
    .o_gpio_oe  (goe),
    .o_irq      (irq)
  );

  typedef struct packed {
    logic [31:0]  rdata;
    logic [W-1:0] out;
    logic [W-1:0] oe;
    logic         irq;
    int           txn;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   txn      = 0;
  bit   model_ok = 0;

  // Reference model: architectural state after the most recent edge.
  logic [W-1:0] m_out;
  logic [W-1:0] m_dir;
  logic [W-1:0] m_status;
  logic [W-1:0] m_sync_prev;
  logic         m_irq;
  logic [W-1:0] m_pin_q[$];   // last S sampled pad values, oldest first

  function automatic logic [31:0] m_read(input logic [31:0] a);
    longint off;
    logic [31:0] r;
    off = longint'(a) - BASE;
    r = 32'h0;
    if (off == 0) r[W-1:0] = m_out;
    else if (off == 1) r[W-1:0] = m_dir;
    else if (off == 2) begin
      r[W-1:0] = m_pin_q[0];
`ifdef GPIO_IRQ_EN
      r[16 +: W] = m_status;
`endif
    end
    return r;
  endfunction

  task automatic model_edge(input bit r, input bit w, input logic [31:0] a,
                            input logic [31:0] d, input logic [W-1:0] p);
    longint off;
    logic [W-1:0] cur_sync;
    logic [W-1:0] clr;
    if (r) begin
      m_out = '0; m_dir = '0; m_status = '0; m_sync_prev = '0; m_irq = 1'b0;
      m_pin_q = {};
      for (int i = 0; i < S; i++) m_pin_q.push_back('0);
      model_ok = 1;
      return;
    end
    off = longint'(a) - BASE;
    cur_sync = m_pin_q[0];
    clr = '0;
    if (w) begin
      if (off == 0) m_out = d[W-1:0];
      else if (off == 1) m_dir = d[W-1:0];
      else if (off == 2) clr = d[16 +: W];
    end
`ifdef GPIO_IRQ_EN
    m_irq    = (m_status != '0);
    m_status = (m_status & ~clr) | (cur_sync & ~m_sync_prev);
`endif
    m_sync_prev = cur_sync;
    m_pin_q.push_back(p);
    void'(m_pin_q.pop_front());
  endtask

  task automatic step(input bit r, input bit w, input logic [31:0] a,
                      input logic [31:0] d, input logic [W-1:0] p);
    exp_t e;
    rst = r; we = w; addr = a; wdata = d; gin = p;
    if (model_ok) begin
      e.rdata = m_read(a);
      e.out   = m_out;
      e.oe    = m_dir;
      e.irq   = m_irq;
      e.txn   = txn;
      sb.push_back(e);
    end
    txn++;
    @(posedge clk);
    model_edge(r, w, a, d, p);
    #1;
  endtask

  task automatic chk(input string nm, input int t, input logic [31:0] act,
                     input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s txn=%0d actual=%h required=%h", nm, t, act, req);
    end
  endtask

  // Monitor: the DUT answers every cycle, so each negedge consumes one entry.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        $display("txn %0d addr=%0d rdata=%h out=%h oe=%h irq=%b",
                 e.txn, addr, rdata, gout, goe, irq);
        chk("rdata", e.txn, rdata, e.rdata);
        chk("gpio_out", e.txn, 32'(gout), 32'(e.out));
        chk("gpio_oe", e.txn, 32'(goe), 32'(e.oe));
        chk("irq", e.txn, 32'(irq), 32'(e.irq));
      end
    end
  end

  initial begin
    int k;
    rst = 1'b1; we = 1'b0; addr = '0; wdata = '0; gin = '0;

    // Reset wins over a same-cycle write
    step(1, 1, 128, 32'hFF, 8'h00);
    step(1, 1, 128, 32'hFF, 8'h00);
    step(0, 0, 128, 32'h0, 8'h00);
    step(0, 0, 129, 32'h0, 8'h00);

    // Write/read, upper store bits ignored
    step(0, 1, 128, 32'hFFFF_FFA5, 8'h00);
    step(0, 1, 129, 32'h0000_000F, 8'h00);
    step(0, 0, 128, 32'h0, 8'h00);
    step(0, 0, 129, 32'h0, 8'h00);

    // Input latency
    step(0, 0, 130, 32'h0, 8'h3C);
    for (int i = 0; i < 4; i++) step(0, 0, 130, 32'h0, 8'h3C);

    // Address bounds
    step(0, 1, 127, 32'hFF, 8'h3C);
    step(0, 1, 131, 32'hFF, 8'h3C);
    step(0, 0, 131, 32'h0, 8'h3C);
    step(0, 0, 128, 32'h0, 8'h3C);
    step(0, 0, 129, 32'h0, 8'h3C);

    // Write to read-only offset
    for (int i = 0; i < 4; i++) step(0, 1, 130, 32'hFF, 8'h00);
    step(0, 0, 130, 32'h0, 8'h00);
    step(0, 0, 128, 32'h0, 8'h00);

    // Pin 3 edge, clear, then clears overlapping a fresh edge
    for (int i = 0; i < 5; i++) step(0, 0, 130, 32'h0, 8'h08);
    step(0, 1, 130, 32'h0008_0000, 8'h08);
    for (int i = 0; i < 3; i++) step(0, 0, 130, 32'h0, 8'h08);
    for (int i = 0; i < 4; i++) step(0, 0, 130, 32'h0, 8'h00);
    for (int i = 0; i < 5; i++) step(0, 1, 130, 32'h0008_0000, 8'h08);
    for (int i = 0; i < 3; i++) step(0, 0, 130, 32'h0, 8'h08);

    // Randomized traffic, including occasional mid-run resets
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1,
           32'($urandom_range(125, 133)), $urandom, W'($urandom));
    end
    step(0, 0, 130, 32'h0, 8'h00);

    k = 0;
    while (sb.size() > 0 && k < 10) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
